// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter: round-robin packetizer for the tx FIFO write port (tag, length LSB first, payload); define TX_PACKET_CHECKSUM_EN to append an XOR checksum byte
module tx_packet_arbiter #(
  parameter int         NREQ     = 3,
  parameter logic [7:0] TAG_BASE = 8'hA0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [16*NREQ-1:0] req_len_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   req_done_o,
  output logic [2:0]        grant_id_o,
  output logic              busy_o,
  input  logic              tx_wfull_i,
  output logic              tx_winc_o,
  output logic [7:0]        tx_wdata_o
);
  typedef enum logic [2:0] {
    IDLE, HDR, LEN_LO, LEN_HI, PAYLOAD, FIN
`ifdef TX_PACKET_CHECKSUM_EN
    , CSUM
`endif
  } state_e;
`ifdef TX_PACKET_CHECKSUM_EN
  localparam state_e TAIL = CSUM;
`else
  localparam state_e TAIL = FIN;
`endif
  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d, last_q, last_d, pick;
  logic [15:0] cnt_q, cnt_d, pick_len;
  logic        any_req, cur_valid;
  logic [7:0]  cur_data;
  // first requester after the last owner (with wrap), and the owner's payload stream
  always_comb begin
    any_req = 1'b0;
    pick = '0;
    pick_len = '0;
    cur_valid = 1'b0;
    cur_data = '0;
    for (int k = NREQ; k >= 1; k--)
      for (int i = 0; i < NREQ; i++)
        if (req_i[i] && i == (int'(last_q) + k) % NREQ) begin
          any_req = 1'b1;
          pick = 3'(i);
        end
    for (int i = 0; i < NREQ; i++) begin
      if (pick == 3'(i)) pick_len = req_len_i[16*i +: 16];
      if (grant_q == 3'(i)) begin
        cur_valid = req_valid_i[i];
        cur_data = req_data_i[8*i +: 8];
      end
    end
  end
`ifdef TX_PACKET_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  // running XOR of every byte written before the checksum, cleared while idle
  always_comb csum_d = state_q == IDLE ? 8'h00 : (tx_winc_o && state_q != CSUM) ? csum_q ^ tx_wdata_o : csum_q;
  // checksum accumulator register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum_q <= '0;
    else csum_q <= csum_d;
`endif
  // packet framing: header bytes, payload pass-through, done pulse
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    cnt_d = cnt_q;
    tx_winc_o = 1'b0;
    tx_wdata_o = '0;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = HDR;
        grant_d = pick;
        cnt_d = pick_len;
      end
      HDR: begin
        tx_wdata_o = TAG_BASE | {5'b0, grant_q};
        tx_winc_o = !tx_wfull_i;
        if (tx_winc_o) state_d = LEN_LO;
      end
      LEN_LO: begin
        tx_wdata_o = cnt_q[7:0];
        tx_winc_o = !tx_wfull_i;
        if (tx_winc_o) state_d = LEN_HI;
      end
      LEN_HI: begin
        tx_wdata_o = cnt_q[15:8];
        tx_winc_o = !tx_wfull_i;
        if (tx_winc_o) state_d = cnt_q != '0 ? PAYLOAD : TAIL;
      end
      PAYLOAD: begin
        tx_wdata_o = cur_data;
        tx_winc_o = cur_valid && !tx_wfull_i;
        if (tx_winc_o) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = TAIL;
        end
      end
`ifdef TX_PACKET_CHECKSUM_EN
      CSUM: begin
        tx_wdata_o = csum_q;
        tx_winc_o = !tx_wfull_i;
        if (tx_winc_o) state_d = FIN;
      end
`endif
      FIN: begin
        last_d = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // per-requester handshake strobes
  always_comb
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = state_q == PAYLOAD && grant_q == 3'(i) && !tx_wfull_i;
      req_done_o[i] = state_q == FIN && grant_q == 3'(i);
    end
  assign busy_o = state_q != IDLE && state_q != FIN;
  assign grant_id_o = grant_q;
  // state, owner, byte counter and round-robin pointer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= 3'(NREQ - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_tx_packet_arbiter.sv
// tb_tx_packet_arbiter: randomized scoreboard bench for tx_packet_arbiter (honours TX_PACKET_CHECKSUM_EN)
module tb_tx_packet_arbiter;
  localparam int N = 3;
  localparam logic [7:0] TAG = 8'hA0;
`ifdef TX_PACKET_CHECKSUM_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 3;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0, req_valid = '0, req_ready, req_done;
  logic [16*N-1:0] req_len = '0;
  logic [8*N-1:0] req_data = '0;
  logic [2:0] grant_id;
  logic busy, tx_wfull = 1'b0, tx_winc;
  logic [7:0] tx_wdata;
  tx_packet_arbiter #(.NREQ(N), .TAG_BASE(TAG)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_len_i(req_len), .req_valid_i(req_valid),
    .req_data_i(req_data), .req_ready_o(req_ready), .req_done_o(req_done), .grant_id_o(grant_id),
    .busy_o(busy), .tx_wfull_i(tx_wfull), .tx_winc_o(tx_winc), .tx_wdata_o(tx_wdata)
  );
  always #5 clk = ~clk;
  logic [7:0] pay [N][64];
  int plen [N];
  int ptr [N];
  logic [N-1:0] active = '0;
  logic [7:0] exp_q [$];
  int done_q [$];
  int vectors = 0, miscompares = 0;
  int valid_pct = 100, full_pct = 0, full_delay = 0, full_hold = 0;
  bit tog_mode = 1'b0, tog = 1'b0;
  int last_m = N - 1;
  int cyc = 0, win_first = -1, win_last = -1;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask
  task automatic prep(input int i, input int n);
    plen[i] = n;
    for (int b = 0; b < n; b++) pay[i][b] = 8'($urandom);
  endtask
  // reference model: round-robin order over the raised set, each packet as tag, len lo, len hi, payload (+ xor)
  task automatic launch(input logic [N-1:0] mask);
    int start, i;
    logic [7:0] x, cs;
    @(negedge clk);
    #1;
    start = last_m;
    for (int k = 1; k <= N; k++) begin
      i = (start + k) % N;
      if (mask[i]) begin
        x = TAG | 8'(i); exp_q.push_back(x); cs = x;
        x = 8'(plen[i]); exp_q.push_back(x); cs ^= x;
        x = 8'(plen[i] >> 8); exp_q.push_back(x); cs ^= x;
        for (int b = 0; b < plen[i]; b++) begin
          exp_q.push_back(pay[i][b]);
          cs ^= pay[i][b];
        end
`ifdef TX_PACKET_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
        done_q.push_back(i);
        req_len[16*i +: 16] = 16'(plen[i]);
        ptr[i] = 0;
        active[i] = 1'b1;
        last_m = i;
      end
    end
    req = req | mask;
  endtask
  task automatic wait_round();
    int t = 0;
    while ((active != '0 || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL round_timeout: %0d bytes outstanding, required 0", exp_q.size());
      finish_now();
    end
    chk("round_dones_left", done_q.size(), 0);
  endtask
  // requester and FIFO-full drivers
  initial begin
    forever begin
      @(negedge clk);
      tog = ~tog;
      for (int i = 0; i < N; i++) begin
        req_data[8*i +: 8] = ptr[i] < plen[i] ? pay[i][ptr[i]] : 8'($urandom);
        req_valid[i] = tog_mode ? tog : ($urandom_range(99) < valid_pct);
      end
      if (full_delay > 0) begin full_delay--; tx_wfull = 1'b0; end
      else if (full_hold > 0) begin full_hold--; tx_wfull = 1'b1; end
      else tx_wfull = $urandom_range(99) < full_pct;
      #4;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) ptr[i]++;
        if (req_done[i]) begin req[i] = 1'b0; active[i] = 1'b0; end
      end
    end
  end
  // monitor: pops the scoreboard on every FIFO write and done pulse
  initial begin
    logic [7:0] e;
    int d;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        cyc++;
        if (tx_winc) begin
          chk("winc_while_full", int'(tx_wfull), 0);
          if (win_first < 0) win_first = cyc;
          win_last = cyc;
          if (exp_q.size() == 0) chk("unexpected_write", int'(tx_wdata), -1);
          else begin
            e = exp_q.pop_front();
            chk("tx_wdata", int'(tx_wdata), int'(e));
          end
        end
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) chk("ready_when_no_payload_due", int'(active[i] && ptr[i] < plen[i]), 1);
          if (req_done[i]) begin
            d = done_q.size() != 0 ? done_q.pop_front() : -1;
            chk("done_order", i, d);
            chk("done_payload_consumed", ptr[i], plen[i]);
          end
        end
      end
    end
  end
  initial begin
    int t;
    logic [N-1:0] mask;
    for (int i = 0; i < N; i++) begin plen[i] = 0; ptr[i] = 0; end
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_done", int'(req_done), 0);
    chk("rst_winc", int'(tx_winc), 0);
    chk("rst_wdata", int'(tx_wdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // single packet, no stalls: back-to-back writes and one-cycle grant latency
    prep(1, 3);
    pay[1][0] = 8'h11; pay[1][1] = 8'h22; pay[1][2] = 8'h33;
    win_first = -1;
    launch(3'b010);
    @(posedge clk);
    #1;
    chk("grant_latency_busy", int'(busy), 1);
    chk("grant_latency_id", int'(grant_id), 1);
    wait_round();
    chk("single_back_to_back", win_last - win_first, 3 + EXTRA - 1);
    // zero length on requester 2 moves the pointer to 2
    prep(2, 0);
    launch(3'b100);
    wait_round();
    // contention: 0 then 2
    prep(0, 1); prep(2, 1);
    launch(3'b101);
    wait_round();
    // back-pressure across LEN_HI
    prep(0, 2);
    full_delay = 2; full_hold = 5;
    launch(3'b001);
    wait_round();
    // zero length on requester 0
    prep(0, 0);
    launch(3'b001);
    wait_round();
    // valid toggling every cycle
    tog_mode = 1'b1;
    prep(2, 4);
    launch(3'b100);
    wait_round();
    tog_mode = 1'b0;
    // asynchronous reset after two of four payload bytes
    prep(1, 4);
    launch(3'b010);
    t = 0;
    while (ptr[1] < 2 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL reset_setup_timeout: ptr %0d required 2", ptr[1]);
      finish_now();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_winc", int'(tx_winc), 0);
    chk("midrst_ready", int'(req_ready), 0);
    chk("midrst_grant_id", int'(grant_id), 0);
    exp_q.delete();
    done_q.delete();
    req = '0;
    active = '0;
    last_m = N - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prep(1, 2);
    launch(3'b010);
    wait_round();
    // randomized rounds with stalls, gaps and late length changes
    for (int r = 0; r < 40; r++) begin
      full_pct = $urandom_range(0, 40);
      valid_pct = $urandom_range(30, 100);
      mask = 3'($urandom_range(1, 7));
      for (int i = 0; i < N; i++)
        if (mask[i]) prep(i, $urandom_range(0, 3) == 0 ? $urandom_range(9, 30) : $urandom_range(0, 8));
      launch(mask);
      if ($countones(mask) == 1) begin
        repeat (3) @(negedge clk);
        req_len = {N{16'($urandom)}};
      end
      wait_round();
    end
    finish_now();
  end
endmodule
